uart_rx_pkt_ctrl: RTL and testbench
===================================

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 16; maximum payload bytes per packet, range 1..255.
REQ-002 Parameter SYNC_BYTE, default 8'hA5; packet start marker.
REQ-003 Parameter TIMEOUT_CYCLES, default 104160; allowed inter-byte gap in clk cycles (two 10-bit frames at 9600 baud, 50 MHz).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, named as below.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 rst  input  1  asynchronous reset, active high.
REQ-007 rx_valid  input  1  one-cycle strobe: received byte available.
REQ-008 rx_data  input  8  received byte, qualified by rx_valid.
REQ-009 rx_break  input  1  BREAK flag, coincident with rx_valid.
REQ-010 rx_en  output  1  receiver enable.
REQ-011 out_valid  output  1  payload byte available downstream.
REQ-012 out_ready  input  1  downstream accepts the byte.
REQ-013 out_data  output  8  payload byte.
REQ-014 out_last  output  1  marks the final payload byte.
REQ-015 pkt_ok  output  1  one-cycle pulse: packet accepted.
REQ-016 pkt_err  output  1  one-cycle pulse: packet aborted.
REQ-017 err_code  output  2  cause, valid with pkt_err: 0 LEN, 1 CKSUM, 2 TIMEOUT, 3 BREAK.
REQ-018 pkt_cnt  output  16  count of accepted packets; wraps.
REQ-019 err_cnt  output  16  count of aborted packets; saturates at 16'hFFFF.

Function
REQ-020 FSM states SHALL be IDLE, LEN, PAYLOAD, CKSUM and DRAIN; unused encodings go to IDLE.
REQ-021 IDLE: rx_valid with rx_data==SYNC_BYTE -> LEN; all other bytes are discarded silently, with no error.
REQ-022 LEN: rx_valid with rx_data==0 or rx_data>MAX_LEN -> pkt_err with code LEN, then IDLE; otherwise latch length L, seed sum=rx_data, -> PAYLOAD.
REQ-023 PAYLOAD: each rx_valid writes buf[idx] (MAX_LEN x 8 storage), sum=(sum+rx_data) mod 256, idx++; the byte with idx==L-1 -> CKSUM.
REQ-024 CKSUM: rx_valid with rx_data==sum -> pkt_ok, pkt_cnt++, DRAIN; mismatch -> pkt_err with code CKSUM, then IDLE.
REQ-025 DRAIN: out_valid=1, out_data=buf[rd], out_last=(rd==L-1); each out_valid&&out_ready advances rd; the handshake on the last byte -> IDLE the next cycle.
REQ-026 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0; out_valid SHALL be 0 outside DRAIN.
REQ-027 rx_en SHALL be 1 in every state except DRAIN; rx_valid in DRAIN is ignored and the byte is dropped.
REQ-028 Gap counter: in LEN, PAYLOAD and CKSUM it counts cycles and clears on rx_valid; reaching TIMEOUT_CYCLES -> pkt_err with code TIMEOUT, then IDLE.
REQ-029 The gap counter SHALL hold at 0 in IDLE and DRAIN.
REQ-030 rx_break in LEN, PAYLOAD or CKSUM SHALL abort with code BREAK, taking priority over data checks; in IDLE or DRAIN it is ignored.
REQ-031 If rx_valid and timeout expiry coincide, the byte wins and no timeout is raised.
REQ-032 At most one of pkt_ok and pkt_err SHALL pulse per cycle; err_cnt increments on each pkt_err.
REQ-033 Error and ok pulses SHALL be registered, asserting one cycle after the triggering rx_valid or expiry.

Reset
REQ-034 Asserting rst SHALL immediately force state IDLE, rx_en=1, out_valid=0, out_last=0, out_data=0, pkt_ok=0, pkt_err=0, err_code=0, pkt_cnt=0, err_cnt=0, and clear idx, rd, sum and the gap counter.
REQ-035 Reset mid-packet or mid-DRAIN SHALL discard the packet with no pulse; buffer contents need not clear.

Configuration
REQ-036 Macro UART_RX_PKT_CKSUM_EN defined: CKSUM state and checksum check present, per REQ-024.
REQ-037 Macro undefined: no CKSUM state and no sum logic; the last PAYLOAD byte pulses pkt_ok, increments pkt_cnt and -> DRAIN; err_code 1 is never produced.

Verification
REQ-038 Macro on: A5,03,11,22,33,69 with out_ready=1 -> pkt_ok; out_data 11,22,33; out_last on 33; pkt_cnt=1.
REQ-039 Macro on: A5,02,10,20,00 -> pkt_err with err_code=1, no out_valid, err_cnt=1.
REQ-040 A5,00 -> err_code=0; A5 followed by an 11h (17) length with MAX_LEN=16 -> err_code=0.
REQ-041 A5,04,AA then 104160 idle cycles -> err_code=2 exactly at expiry; a byte on the expiry cycle instead -> no error.
REQ-042 DRAIN with out_ready toggling 1,0,0,1 and rx_valid injected -> rx_en=0, data held stable, injected byte dropped.
REQ-043 rst pulsed mid-PAYLOAD, then a clean packet -> only the clean packet is delivered; counters restart from 0.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: turns a UART byte stream into length-framed packets.
// Frame: SYNC_BYTE, length L (1..MAX_LEN), L payload bytes[, checksum].
// Accepted payloads are buffered and then streamed out over a valid/ready port.
// The receiver is disabled while a packet drains.
// Build option: define UART_RX_PKT_CKSUM_EN to add a trailing checksum byte.
// The checksum is the 8-bit sum of L and the payload bytes.
// Without it, a packet is accepted on its last payload byte.
module uart_rx_pkt_ctrl #(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 104160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  output logic        rx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] E_LEN     = 2'd0;
`ifdef UART_RX_PKT_CKSUM_EN
  localparam logic [1:0] E_CKSUM   = 2'd1;
`endif
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_BREAK   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
`ifdef UART_RX_PKT_CKSUM_EN
    S_CKSUM   = 3'd3,
`endif
    S_DRAIN   = 3'd4
  } state_t;

  // Saturating increment used by the error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         len_m1_q, len_m1_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rd_q, rd_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
`ifdef UART_RX_PKT_CKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif
  logic               rx_en_q, rx_en_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               pkt_ok_q, pkt_ok_d;
  logic               pkt_err_q, pkt_err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic               in_pkt;
  logic               abort;
  logic [1:0]         abort_code;
  logic               accept;
  logic               buf_we;

  // Payload storage; contents are only read in DRAIN, so it carries no reset.
  logic [7:0]         pay_mem [MAX_LEN];

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d     = state_q;
    len_m1_d    = len_m1_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    gap_d       = gap_q;
`ifdef UART_RX_PKT_CKSUM_EN
    sum_d       = sum_q;
`endif
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    abort       = 1'b0;
    abort_code  = E_LEN;
    accept      = 1'b0;
    buf_we      = 1'b0;
    in_pkt      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = S_LEN;
      end
      S_LEN: begin
        in_pkt = 1'b1;
        if (rx_valid && !rx_break) begin
          if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
            abort      = 1'b1;
            abort_code = E_LEN;
          end else begin
            len_m1_d = rx_data - 8'd1;
            idx_d    = '0;
`ifdef UART_RX_PKT_CKSUM_EN
            sum_d    = rx_data;
`endif
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        in_pkt = 1'b1;
        if (rx_valid && !rx_break) begin
          buf_we = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
`ifdef UART_RX_PKT_CKSUM_EN
          sum_d  = sum_q + rx_data;
          if (8'(idx_q) == len_m1_q) state_d = S_CKSUM;
`else
          if (8'(idx_q) == len_m1_q) accept = 1'b1;
`endif
        end
      end
`ifdef UART_RX_PKT_CKSUM_EN
      S_CKSUM: begin
        in_pkt = 1'b1;
        if (rx_valid && !rx_break) begin
          if (rx_data == sum_q) begin
            accept = 1'b1;
          end else begin
            abort      = 1'b1;
            abort_code = E_CKSUM;
          end
        end
      end
`endif
      S_DRAIN: begin
        // out_valid is asserted throughout DRAIN, so out_ready alone completes a beat.
        if (out_ready) begin
          if (8'(rd_q) == len_m1_q) begin
            state_d = S_IDLE;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte gap supervision and BREAK abort, shared by all in-packet states.
    // A byte arriving on the expiry cycle clears the gap instead of timing out.
    if (in_pkt) begin
      if (rx_valid) begin
        gap_d = '0;
        if (rx_break) begin
          abort      = 1'b1;
          abort_code = E_BREAK;
        end
      end else if (gap_q == GAP_LAST) begin
        gap_d      = '0;
        abort      = 1'b1;
        abort_code = E_TIMEOUT;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      gap_d = '0;
    end

    if (abort) begin
      state_d    = S_IDLE;
      pkt_err_d  = 1'b1;
      err_code_d = abort_code;
      err_cnt_d  = sat_inc16(err_cnt_q);
    end else if (accept) begin
      state_d   = S_DRAIN;
      rd_d      = '0;
      pkt_ok_d  = 1'b1;
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    out_valid_d = (state_d == S_DRAIN);
    rx_en_d     = !out_valid_d;
    out_last_d  = out_valid_d && (8'(rd_d) == len_m1_d);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_m1_q    <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      gap_q       <= '0;
`ifdef UART_RX_PKT_CKSUM_EN
      sum_q       <= '0;
`endif
      rx_en_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_m1_q    <= len_m1_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      gap_q       <= gap_d;
`ifdef UART_RX_PKT_CKSUM_EN
      sum_q       <= sum_d;
`endif
      rx_en_q     <= rx_en_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Payload capture.
  always_ff @(posedge clk) begin
    if (buf_we) pay_mem[idx_q] <= rx_data;
  end

  assign rx_en     = rx_en_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_valid_q ? pay_mem[rd_q] : 8'h00;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl.
// The timeout is shortened so the expiry case fits a short run.
module tb_uart_rx_pkt_ctrl;
  localparam int unsigned MAX_LEN = 16;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int unsigned TMO     = 40;
  localparam int          EV_OK   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_break, out_ready;
  logic [7:0]  rx_data;
  logic        rx_en, out_valid, out_last, pkt_ok, pkt_err;
  logic [7:0]  out_data;
  logic [1:0]  err_code;
  logic [15:0] pkt_cnt, err_cnt;

  int total = 0;
  int bad   = 0;
  int exp_ok  = 0;
  int exp_err = 0;
  logic [8:0] exp_bytes [$];
  int         exp_evt [$];
  logic [7:0] pl [16];
  logic [8:0] mon_b;
  int         mon_e;
  int         act_e;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
    .rx_en(rx_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops expected output beats and packet events as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL out_byte: actual=%0h required=none", {out_last, out_data});
        end else begin
          mon_b = exp_bytes.pop_front();
          check("out_byte", 32'({out_last, out_data}), 32'(mon_b));
        end
      end
      if (pkt_ok || pkt_err) begin
        act_e = pkt_ok ? EV_OK : int'(err_code);
        if (pkt_ok && pkt_err) begin
          total++; bad++;
          $display("FAIL ok_err_both: actual=both required=one");
        end else if (exp_evt.size() == 0) begin
          total++; bad++;
          $display("FAIL pkt_event: actual=%0d required=none", act_e);
        end else begin
          mon_e = exp_evt.pop_front();
          check("pkt_event", 32'(act_e), 32'(mon_e));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic brk = 1'b0);
    rx_valid = 1'b1; rx_data = b; rx_break = brk;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends a well-formed packet from pl[0..n-1] and queues its expected outputs.
  task automatic send_good(input int n);
`ifdef UART_RX_PKT_CKSUM_EN
    logic [7:0] s;
    s = 8'(n);
    for (int i = 0; i < n; i++) s = s + pl[i];
`endif
    exp_evt.push_back(EV_OK);
    exp_ok++;
    for (int i = 0; i < n; i++) exp_bytes.push_back({(i == n - 1), pl[i]});
    send_byte(SYNC);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_byte(pl[i]);
`ifdef UART_RX_PKT_CKSUM_EN
    send_byte(s);
`endif
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(rx_en && !out_valid) && k < 200) begin @(posedge clk); #1; k++; end
    if (k >= 200) begin
      total++; bad++;
      $display("FAIL drain_wait: actual=stuck required=idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_rx_en",     32'(rx_en),     32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_pulses",    32'({pkt_ok, pkt_err}), 32'd0);
    check("rst_err_code",  32'(err_code),  32'd0);
    check("rst_pkt_cnt",   32'(pkt_cnt),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Noise in IDLE is ignored, then a basic 3-byte packet.
    send_byte(8'h42);
    idle(2);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_good(3);
    wait_idle();
    idle(2);
    check("pkt_cnt_1", 32'(pkt_cnt), 32'd1);

    // Single-byte and maximum-length packets.
    pl[0] = 8'h7E;
    send_good(1);
    wait_idle();
    for (int i = 0; i < 16; i++) pl[i] = 8'(8'h30 + i);
    send_good(16);
    wait_idle();
    idle(2);
    check("pkt_cnt_3", 32'(pkt_cnt), 32'd3);

    // Length errors: zero and MAX_LEN+1.
    exp_evt.push_back(0); exp_err++;
    send_byte(SYNC); send_byte(8'h00);
    idle(2);
    exp_evt.push_back(0); exp_err++;
    send_byte(SYNC); send_byte(8'h11);
    idle(2);
    check("err_cnt_len", 32'(err_cnt), 32'(exp_err));

`ifdef UART_RX_PKT_CKSUM_EN
    // Checksum mismatch: 02+10+20 = 32, 00 received.
    exp_evt.push_back(1); exp_err++;
    send_byte(SYNC); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    idle(2);
    check("err_cnt_ck", 32'(err_cnt), 32'(exp_err));
`endif

    // Timeout: error appears exactly one cycle after the TMO-th idle cycle.
    exp_evt.push_back(2); exp_err++;
    send_byte(SYNC); send_byte(8'h04); send_byte(8'hAA);
    idle(TMO - 1);
    check("tmo_early", 32'(pkt_err), 32'd0);
    idle(1);
    check("tmo_pulse", 32'({pkt_err, err_code}), 32'h6);
    idle(2);

    // A byte on the expiry cycle wins over the timeout.
    exp_evt.push_back(EV_OK); exp_ok++;
    exp_bytes.push_back(9'h0AA); exp_bytes.push_back(9'h0BB);
    exp_bytes.push_back(9'h0CC); exp_bytes.push_back(9'h1DD);
    send_byte(SYNC); send_byte(8'h04); send_byte(8'hAA);
    idle(TMO - 1);
    send_byte(8'hBB);
    check("tmo_byte_wins", 32'(pkt_err), 32'd0);
    send_byte(8'hCC); send_byte(8'hDD);
`ifdef UART_RX_PKT_CKSUM_EN
    send_byte(8'h12);
`endif
    wait_idle();
    idle(2);

    // BREAK: ignored in IDLE, aborts mid-payload.
    send_byte(8'h00, 1'b1);
    exp_evt.push_back(3); exp_err++;
    send_byte(SYNC); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22, 1'b1);
    idle(2);
    check("err_cnt_brk", 32'(err_cnt), 32'(exp_err));
    check("pkt_cnt_brk", 32'(pkt_cnt), 32'(exp_ok));

    // DRAIN under backpressure 1,0,0,1 with an injected byte.
    out_ready = 1'b0;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_good(3);
    check("drn_valid", 32'(out_valid), 32'd1);
    check("drn_rx_en", 32'(rx_en), 32'd0);
    check("drn_first", 32'({out_last, out_data}), 32'h001);
    rx_valid = 1'b1; rx_data = SYNC;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
    check("drn_hold0", 32'({out_last, out_data}), 32'h001);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("drn_adv1", 32'({out_last, out_data}), 32'h002);
    idle(1);
    check("drn_hold1", 32'({out_last, out_data}), 32'h002);
    idle(1);
    check("drn_hold2", 32'({out_last, out_data}), 32'h002);
    out_ready = 1'b1;
    idle(1);
    check("drn_last", 32'({out_last, out_data}), 32'h103);
    idle(1);
    check("drn_done", 32'({rx_en, out_valid}), 32'h2);
    idle(2);

    // Reset mid-payload discards the packet and clears counters.
    check("pre_rst_cnt", 32'(pkt_cnt), 32'(exp_ok));
    send_byte(SYNC); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    #2;
    check("async_rst_cnt", 32'({pkt_cnt, err_cnt}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ok = 0; exp_err = 0;
    idle(1);
    pl[0] = 8'h5A; pl[1] = 8'h6B;
    send_good(2);
    wait_idle();
    idle(2);
    check("post_rst_pkt", 32'(pkt_cnt), 32'(exp_ok));
    check("post_rst_err", 32'(err_cnt), 32'd0);
    check("sb_bytes_empty", 32'(exp_bytes.size()), 32'd0);
    check("sb_evt_empty", 32'(exp_evt.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
